// File: rtl/video_pkg.sv
// Types and defaults shared by the test-pattern video generator and its flash sequencer.
// The sequencer state encoding lives here so monitors and the generator agree on it.
package video_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_FB = 2'd1,
      ON      = 2'd2,
      OFF     = 2'd3
   } seq_state_t;

   // Level of vsync while sync is asserted, as produced by the timing generator
   localparam logic VSYNC_POL_DEFAULT = 1'b0;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers a timing signal twice and flags the cycle where the registered copy
// first reaches the ACTIVE level.
module sync_edge_detect #(
   parameter logic ACTIVE = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic sig_in,
   output logic active_edge
);

   logic sig_q_reg;
   logic sig_prev_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         sig_q_reg    <= 1'b0;
         sig_prev_reg <= 1'b0;
      end else begin
         sig_q_reg    <= sig_in;
         sig_prev_reg <= sig_q_reg;
      end
   end

   assign active_edge = (sig_q_reg == ACTIVE) && (sig_prev_reg != ACTIVE);

endmodule

// File: rtl/flash_sequencer.sv
// Frame-synchronous ON/OFF flash scheduler for the lag-tester pattern generator.
// Flash level only moves on frame boundaries; measure_start marks the first active pixel of each ON period.
module flash_sequencer
   import video_pkg::*;
#(
   parameter logic VSYNC_POL = VSYNC_POL_DEFAULT,
   parameter int   FRAME_W   = 8,
   parameter int   REPEAT_W  = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                vsync_in,
   input  logic                de_in,
   input  logic                start,
   input  logic                stop,
   input  logic [FRAME_W-1:0]  on_frames,
   input  logic [FRAME_W-1:0]  off_frames,
   input  logic [REPEAT_W-1:0] repeat_count,
   output logic                flash,
   output logic                measure_start,
   output logic                busy,
   output logic                done,
   output logic [REPEAT_W-1:0] cycles_done
);

   // Bit 0 tracks vsync (active at VSYNC_POL), bit 1 tracks de (active high)
   localparam logic [1:0] EDGE_LEVEL = {1'b1, VSYNC_POL};

   logic [1:0] raw_in;
   logic [1:0] edge_hit;
   logic       fb;
   logic       de_rise;

   assign raw_in = {de_in, vsync_in};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_edge
         sync_edge_detect #(
            .ACTIVE (EDGE_LEVEL[gi])
         ) u_edge (
            .clock       (clock),
            .reset       (reset),
            .sig_in      (raw_in[gi]),
            .active_edge (edge_hit[gi])
         );
      end
   endgenerate

   assign fb      = edge_hit[0];
   assign de_rise = edge_hit[1];

   seq_state_t          state_reg,         state_next;
   logic                flash_reg,         flash_next;
   logic                armed_reg,         armed_next;
   logic                measure_reg,       measure_next;
   logic                done_reg,          done_next;
   logic [FRAME_W-1:0]  frame_cnt_reg,     frame_cnt_next;
   logic [REPEAT_W-1:0] cycles_done_reg,   cycles_done_next;
   logic [FRAME_W-1:0]  on_reg,            on_next;
   logic [FRAME_W-1:0]  off_reg,           off_next;
   logic [REPEAT_W-1:0] repeat_reg,        repeat_next;
   logic [REPEAT_W-1:0] cycles_inc;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= IDLE;
         flash_reg       <= 1'b0;
         armed_reg       <= 1'b0;
         measure_reg     <= 1'b0;
         done_reg        <= 1'b0;
         frame_cnt_reg   <= '0;
         cycles_done_reg <= '0;
         on_reg          <= '0;
         off_reg         <= '0;
         repeat_reg      <= '0;
      end else begin
         state_reg       <= state_next;
         flash_reg       <= flash_next;
         armed_reg       <= armed_next;
         measure_reg     <= measure_next;
         done_reg        <= done_next;
         frame_cnt_reg   <= frame_cnt_next;
         cycles_done_reg <= cycles_done_next;
         on_reg          <= on_next;
         off_reg         <= off_next;
         repeat_reg      <= repeat_next;
      end
   end

   assign cycles_inc = cycles_done_reg + REPEAT_W'(1);

   always_comb begin
      state_next       = state_reg;
      flash_next       = flash_reg;
      armed_next       = armed_reg;
      measure_next     = 1'b0;
      done_next        = 1'b0;
      frame_cnt_next   = frame_cnt_reg;
      cycles_done_next = cycles_done_reg;
      on_next          = on_reg;
      off_next         = off_reg;
      repeat_next      = repeat_reg;

      if (stop) begin
         state_next = IDLE;
         flash_next = 1'b0;
         armed_next = 1'b0;
      end else begin
         // Armed once per ON period; frame-boundary branches below re-arm it
         if (state_reg == ON && armed_reg && de_rise) begin
            measure_next = 1'b1;
            armed_next   = 1'b0;
         end

         unique case (state_reg)
            IDLE: begin
               if (start) begin
                  on_next          = (on_frames  == '0) ? FRAME_W'(1) : on_frames;
                  off_next         = (off_frames == '0) ? FRAME_W'(1) : off_frames;
                  repeat_next      = repeat_count;
                  cycles_done_next = '0;
                  frame_cnt_next   = '0;
                  state_next       = WAIT_FB;
               end
            end
            WAIT_FB: begin
               if (fb) begin
                  state_next     = ON;
                  flash_next     = 1'b1;
                  frame_cnt_next = '0;
                  armed_next     = 1'b1;
               end
            end
            ON: begin
               if (fb) begin
                  if (frame_cnt_reg == on_reg - FRAME_W'(1)) begin
                     state_next     = OFF;
                     flash_next     = 1'b0;
                     frame_cnt_next = '0;
                  end else begin
                     frame_cnt_next = frame_cnt_reg + FRAME_W'(1);
                  end
               end
            end
            OFF: begin
               if (fb) begin
                  if (frame_cnt_reg == off_reg - FRAME_W'(1)) begin
                     cycles_done_next = cycles_inc;
                     if (repeat_reg != '0 && cycles_inc == repeat_reg) begin
                        state_next = IDLE;
                        flash_next = 1'b0;
                        done_next  = 1'b1;
                     end else begin
                        state_next     = ON;
                        flash_next     = 1'b1;
                        armed_next     = 1'b1;
                        frame_cnt_next = '0;
                     end
                  end else begin
                     frame_cnt_next = frame_cnt_reg + FRAME_W'(1);
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign flash         = flash_reg;
   assign measure_start = measure_reg;
   assign busy          = (state_reg != IDLE);
   assign done          = done_reg;
   assign cycles_done   = cycles_done_reg;

endmodule
